// File: rtl/patch_fetch_ctrl_if.sv
// Cache request bus between patch_fetch_ctrl (master) and cache_tfg (slave).
interface patch_fetch_ctrl_if #(
   parameter int N          = 16,
   parameter int ADDR_WIDTH = 21
);
   logic                  request;
   logic                  read_write;
   logic [ADDR_WIDTH-1:0] address;
   logic [N-1:0]          cache_data;
   logic                  cache_valid;
   logic                  cache_error;

   modport master (
      output request, read_write, address,
      input  cache_data, cache_valid, cache_error
   );

   modport slave (
      input  request, read_write, address,
      output cache_data, cache_valid, cache_error
   );
endinterface

// File: rtl/patch_fetch_ctrl.sv
// Walks a patching mask, reads one activation per set bit from the cache and writes it into
// activation_cache. Optional one-shot retry per index when PATCH_FETCH_RETRY_EN is defined.
module patch_fetch_ctrl #(
   parameter int N          = 16,
   parameter int M          = 16,
   parameter int ADDR_WIDTH = 21,
   parameter int TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [M-1:0]          p_mask,
   patch_fetch_ctrl_if.master    cache,
   output logic [$clog2(M)-1:0]  store_index,
   output logic [N-1:0]          store_data,
   output logic                  store_enable,
   output logic [M-1:0]          p_out,
   output logic                  busy,
   output logic                  done,
   output logic                  fetch_error
);
   localparam int IW = $clog2(M);
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT, DONE} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] address_q, address_d;
   logic [M-1:0]          pending_q, pending_d;
   logic [M-1:0]          p_out_q, p_out_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  request_q, request_d;
   logic                  done_q, done_d;
   logic                  fetch_error_q, fetch_error_d;
`ifdef PATCH_FETCH_RETRY_EN
   logic                  retried_q, retried_d;
`endif

   logic [IW-1:0] low_idx;
   logic          resp_ok;
   logic          resp_fail;

   // Scan from the top so the last assignment is the lowest set bit.
   always_comb begin
      low_idx = '0;
      for (int unsigned i = 0; i < M; i++) begin
         if (pending_q[M-1-i]) low_idx = IW'(M-1-i);
      end
   end

   // A timeout is only declared when no response arrives in the final WAIT cycle.
   assign resp_ok   = (state_q == WAIT) && cache.cache_valid && !cache.cache_error;
   assign resp_fail = (state_q == WAIT) &&
                      (cache.cache_error || (!cache.cache_valid && cnt_q == CW'(TIMEOUT - 1)));

   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      address_d     = address_q;
      pending_d     = pending_q;
      p_out_d       = p_out_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      request_d     = 1'b0;
      done_d        = 1'b0;
      fetch_error_d = fetch_error_q;
`ifdef PATCH_FETCH_RETRY_EN
      retried_d     = retried_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               base_d        = base_addr;
               pending_d     = p_mask;
               p_out_d       = '0;
               fetch_error_d = 1'b0;
               state_d       = SCAN;
            end
         end
         SCAN: begin
`ifdef PATCH_FETCH_RETRY_EN
            retried_d = 1'b0;
`endif
            if (pending_q == '0) begin
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               idx_d     = low_idx;
               address_d = base_q + ADDR_WIDTH'(low_idx);
               request_d = 1'b1;
               state_d   = REQ;
            end
         end
         REQ: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (resp_ok) begin
               p_out_d[idx_q]   = 1'b1;
               pending_d[idx_q] = 1'b0;
               state_d          = SCAN;
            end else if (resp_fail) begin
`ifdef PATCH_FETCH_RETRY_EN
               if (!retried_q) begin
                  retried_d = 1'b1;
                  request_d = 1'b1;
                  state_d   = REQ;
               end else begin
                  fetch_error_d    = 1'b1;
                  pending_d[idx_q] = 1'b0;
                  state_d          = SCAN;
               end
`else
               fetch_error_d    = 1'b1;
               pending_d[idx_q] = 1'b0;
               state_d          = SCAN;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         base_q        <= '0;
         address_q     <= '0;
         pending_q     <= '0;
         p_out_q       <= '0;
         idx_q         <= '0;
         cnt_q         <= '0;
         request_q     <= 1'b0;
         done_q        <= 1'b0;
         fetch_error_q <= 1'b0;
`ifdef PATCH_FETCH_RETRY_EN
         retried_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         base_q        <= base_d;
         address_q     <= address_d;
         pending_q     <= pending_d;
         p_out_q       <= p_out_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         request_q     <= request_d;
         done_q        <= done_d;
         fetch_error_q <= fetch_error_d;
`ifdef PATCH_FETCH_RETRY_EN
         retried_q     <= retried_d;
`endif
      end
   end

   assign cache.request    = request_q;
   assign cache.read_write = 1'b1;
   assign cache.address    = address_q;

   assign store_enable = resp_ok;
   assign store_index  = idx_q;
   assign store_data   = resp_ok ? cache.cache_data : '0;
   assign p_out        = p_out_q;
   assign busy         = (state_q != IDLE);
   assign done         = done_q;
   assign fetch_error  = fetch_error_q;
endmodule

// File: tb/tb_patch_fetch_ctrl.sv
// Self-checking bench for patch_fetch_ctrl: cache responder, transaction-level model, per-cycle compare.
module tb_patch_fetch_ctrl;
   localparam int N  = 16;
   localparam int M  = 16;
   localparam int AW = 21;
   localparam int TO = 64;
`ifdef PATCH_FETCH_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [M-1:0]  p_mask;
   logic [3:0]    store_index;
   logic [N-1:0]  store_data;
   logic          store_enable;
   logic [M-1:0]  p_out;
   logic          busy;
   logic          done;
   logic          fetch_error;

   patch_fetch_ctrl_if #(.N(N), .ADDR_WIDTH(AW)) cif ();

   patch_fetch_ctrl #(.N(N), .M(M), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .base_addr    (base_addr),
      .p_mask       (p_mask),
      .cache        (cif.master),
      .store_index  (store_index),
      .store_data   (store_data),
      .store_enable (store_enable),
      .p_out        (p_out),
      .busy         (busy),
      .done         (done),
      .fetch_error  (fetch_error)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endfunction

   // Cache responder: answers L WAIT cycles after each request with 0xA000+addr[3:0].
   int            lat = 1;
   int            cd = 0;
   int            err_left = 0;
   logic [AW-1:0] err_addr = '0;
   logic [AW-1:0] paddr = '0;
   bit            silent = 1'b0;

   initial begin
      cif.cache_valid = 1'b0;
      cif.cache_error = 1'b0;
      cif.cache_data  = 16'hDEAD;
      forever begin
         @(negedge clk);
         cif.cache_valid = 1'b0;
         cif.cache_error = 1'b0;
         cif.cache_data  = 16'hDEAD;
         if (cd > 0) begin
            cd--;
            if (cd == 0 && !silent) begin
               cif.cache_valid = 1'b1;
               cif.cache_data  = 16'hA000 + 16'(paddr[3:0]);
               if (paddr == err_addr && err_left > 0) begin
                  cif.cache_error = 1'b1;
                  err_left--;
               end
            end
         end
         if (cif.request) begin
            paddr = cif.address;
            cd    = lat;
         end
      end
   end

   // Expected transaction stream for one pass.
   logic [AW-1:0]   exp_req[$];
   logic [19:0]     exp_st[$];
   logic [M-1:0]    exp_pout;
   logic            exp_fe;
   int              exp_done;
   logic [AW-1:0]   obs_req[$];
   logic [19:0]     obs_st[$];
   int              obs_done;
   logic [M-1:0]    obs_pout;
   logic            obs_fe;

   task automatic build_model(input logic [AW-1:0] b, input logic [M-1:0] m, input int l,
                              input logic [AW-1:0] ea, input int ec, input bit sil);
      int c;
      int el;
      bit ok;
      c = 0;
      el = ec;
      exp_pout = '0;
      exp_fe = 1'b0;
      exp_req.delete();
      exp_st.delete();
      for (int i = 0; i < M; i++) begin
         if (m[i]) begin
            logic [AW-1:0] a;
            a = b + AW'(i);
            c += 1;
            for (int att = 0; att < (RETRY ? 2 : 1); att++) begin
               exp_req.push_back(a);
               if (sil) begin
                  c += 1 + TO;
                  ok = 1'b0;
               end else begin
                  c += 1 + l;
                  ok = !(a == ea && el > 0);
                  if (!ok) el--;
               end
               if (ok) begin
                  exp_st.push_back({4'(i), 16'hA000 + 16'(a[3:0])});
                  exp_pout[i] = 1'b1;
                  break;
               end
            end
            if (!exp_pout[i]) exp_fe = 1'b1;
         end
      end
      exp_done = c + 2;
   endtask

   // Compare process: every cycle, against the model during a pass and against idle values otherwise.
   bit active   = 1'b0;
   bit idle_chk = 1'b0;
   int cyc      = 0;

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (active) begin
            cyc++;
            chk("read_write", cif.read_write, 1);
            chk("busy_pass", busy, 1);
            if (cif.request) begin
               obs_req.push_back(cif.address);
               if (exp_req.size() == 0) chk("req_extra", cif.address, 32'hFFFFFFFF);
               else chk("req_addr", cif.address, exp_req.pop_front());
            end
            if (store_enable) begin
               obs_st.push_back({store_index, store_data});
               if (exp_st.size() == 0) chk("store_extra", {store_index, store_data}, 32'hFFFFFFFF);
               else chk("store", {store_index, store_data}, exp_st.pop_front());
            end
            if (done) begin
               obs_done = cyc;
               obs_pout = p_out;
               obs_fe   = fetch_error;
               chk("done_cycle", cyc, exp_done);
               chk("p_out", p_out, exp_pout);
               chk("fetch_error", fetch_error, exp_fe);
               chk("req_missing", exp_req.size(), 0);
               chk("store_missing", exp_st.size(), 0);
               active = 1'b0;
            end
         end else if (idle_chk) begin
            chk("idle_request", cif.request, 0);
            chk("idle_store_en", store_enable, 0);
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
         end
      end
   end

   task automatic run_pass(input string nm, input logic [AW-1:0] b, input logic [M-1:0] m,
                           input int l, input logic [AW-1:0] ea, input int ec, input bit sil,
                           input bit poke);
      build_model(b, m, l, ea, ec, sil);
      lat = l;
      err_addr = ea;
      err_left = ec;
      silent = sil;
      obs_req.delete();
      obs_st.delete();
      obs_done = -1;
      @(negedge clk);
      base_addr = b;
      p_mask = m;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      base_addr = 21'h155555;
      p_mask = 16'h5A5A;
      cyc = 0;
      active = 1'b1;
      for (int i = 0; i < 400 && active; i++) begin
         @(posedge clk);
         #1;
         if (poke && i == 2) begin
            start = 1'b1;
            base_addr = 21'h0ABCDE;
            p_mask = '1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      if (active) begin
         chk({nm, "_done_seen"}, 0, 1);
         active = 1'b0;
      end
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_request"}, cif.request, 0);
      chk({nm, "_address"}, cif.address, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_p_out"}, p_out, 0);
      chk({nm, "_fetch_error"}, fetch_error, 0);
      chk({nm, "_store_en"}, store_enable, 0);
      chk({nm, "_store_index"}, store_index, 0);
      chk({nm, "_store_data"}, store_data, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      start = 1'b0;
      base_addr = '0;
      p_mask = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("rst");
      reset = 1'b1;
      idle_chk = 1'b1;
      repeat (2) @(posedge clk);

      // T1: empty mask
      run_pass("t1", 21'h12345, 16'h0000, 1, '0, 0, 1'b0, 1'b0);
      chk("t1_done_lit", obs_done, 2);
      chk("t1_nreq_lit", obs_req.size(), 0);
      chk("t1_pout_lit", obs_pout, 0);

      // T2: two slots, L=1, start pulse while busy
      run_pass("t2", 21'h00100, 16'h0005, 1, '0, 0, 1'b0, 1'b1);
      chk("t2_req0_lit", obs_req[0], 32'h00100);
      chk("t2_req1_lit", obs_req[1], 32'h00102);
      chk("t2_st0_lit", obs_st[0], 32'h0A000);
      chk("t2_st1_lit", obs_st[1], 32'h2A002);
      chk("t2_done_lit", obs_done, 8);
      chk("t2_pout_lit", obs_pout, 16'h0005);

      // T3: persistent error (also wins over simultaneous valid)
      run_pass("t3", 21'h00100, 16'h0005, 1, 21'h00102, 99, 1'b0, 1'b0);
      chk("t3_pout_lit", obs_pout, 16'h0001);
      chk("t3_fe_lit", obs_fe, 1);
      chk("t3_nst_lit", obs_st.size(), 1);

      // T4: address wrap, silent cache -> timeout
      run_pass("t4", 21'h1FFFFF, 16'h0002, 1, '0, 0, 1'b1, 1'b0);
      chk("t4_addr_lit", obs_req[0], 0);
      chk("t4_fe_lit", obs_fe, 1);
      chk("t4_done_lit", obs_done, RETRY ? 133 : 68);

      // T7: slots at both mask ends, wrapping upper slot, L=3
      run_pass("t7", 21'h1FFFF8, 16'h8001, 3, '0, 0, 1'b0, 1'b1);
      chk("t7_req1_lit", obs_req[1], 32'h00007);
      chk("t7_st1_lit", obs_st[1], 32'hFA007);

      // T5: reset mid-WAIT, late response after reset must not store
      lat = 5;
      silent = 1'b0;
      err_left = 0;
      idle_chk = 1'b0;
      @(negedge clk);
      base_addr = 21'h00040;
      p_mask = 16'h0001;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #2;
         if (cif.request) break;
      end
      chk("t5_req_addr", cif.address, 32'h00040);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_reset_vals("t5");
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle_chk = 1'b1;
      repeat (8) @(posedge clk);
      run_pass("t5b", 21'h00200, 16'h0003, 2, '0, 0, 1'b0, 1'b1);

      // T6: first response to idx3 is an error, second one valid
      run_pass("t6", 21'h00300, 16'h0008, 2, 21'h00303, 1, 1'b0, 1'b0);
      chk("t6_nreq_lit", obs_req.size(), RETRY ? 2 : 1);
      chk("t6_nst_lit", obs_st.size(), RETRY ? 1 : 0);
      chk("t6_fe_lit", obs_fe, RETRY ? 0 : 1);

      // T8: full mask with one failing slot
      run_pass("t8", 21'h01000, 16'hFFFF, 1, 21'h01007, 99, 1'b0, 1'b0);
      chk("t8_pout_lit", obs_pout, 16'hFF7F);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
